branch_flag_unit: RTL and testbench

- Producer side of the branch condition flags (ZA, ZB, NA, NB, CA, CB) consumed by the branch-taken evaluator.
- Derives zero, sign and carry flags from each EX-stage result targeting accumulator A or B.
- Holds each result for one pipeline stage (MEM), then commits it to architectural flag registers.
- Presents forwarded flags so a branch in decode sees the youngest in-flight update without waiting for commit.

---
 rtl/branch_flag_if.sv | 22 ++
 rtl/branch_flag_unit.sv | 74 +++++++
 tb/tb_branch_flag_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/branch_flag_if.sv
// EX-stage flag-writing handshake plus the forwarded branch flags it feeds.
// The master drives the EX side; the slave (the flag unit) drives the flags.
interface branch_flag_if #(parameter int DATA_WIDTH = 8);
  logic                  ex_valid;
  logic                  ex_dest;
  logic [DATA_WIDTH-1:0] ex_result;
  logic                  ex_carry;
  logic                  ex_carry_we;
  logic                  stall;
  logic                  flush;
  logic                  ZA, NA, CA, ZB, NB, CB;
  logic                  pend_a, pend_b;

  modport master (
    output ex_valid, ex_dest, ex_result, ex_carry, ex_carry_we, stall, flush,
    input  ZA, NA, CA, ZB, NB, CB, pend_a, pend_b
  );
  modport slave (
    input  ex_valid, ex_dest, ex_result, ex_carry, ex_carry_we, stall, flush,
    output ZA, NA, CA, ZB, NB, CB, pend_a, pend_b
  );
endinterface

// File: rtl/branch_flag_unit.sv
// Zero/sign/carry flags for accumulators A and B.
// Each update sits in a one-entry MEM stage, then commits to the architectural flags.
module branch_flag_unit #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  branch_flag_if.slave bus
);
  typedef struct packed {
    logic z;
    logic n;
    logic c;
  } flags_t;

  // Index 0 = accumulator A, index 1 = accumulator B.
  flags_t [1:0] arch_q, arch_d;
  flags_t       m_q, m_d;
  logic         m_valid_q, m_valid_d;
  logic         m_dest_q, m_dest_d;
  flags_t [1:0] fwd;
  flags_t       ex_f;

  // The youngest in-flight entry overrides the committed value of its accumulator.
  always_comb begin
    fwd = arch_q;
    if (m_valid_q) fwd[m_dest_q] = m_q;
  end

  // Carry-preserving ops take the forwarded C so back-to-back updates chain correctly.
  always_comb begin
    ex_f.z = (bus.ex_result == '0);
    ex_f.n = bus.ex_result[DATA_WIDTH-1];
    ex_f.c = bus.ex_carry_we ? bus.ex_carry : fwd[bus.ex_dest].c;
  end

  always_comb begin
    arch_d    = arch_q;
    m_valid_d = m_valid_q;
    m_dest_d  = m_dest_q;
    m_d       = m_q;
    if (!bus.stall) begin
      if (m_valid_q) arch_d[m_dest_q] = m_q;
      m_valid_d = bus.ex_valid && !bus.flush;
      if (m_valid_d) begin
        m_dest_d = bus.ex_dest;
        m_d      = ex_f;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arch_q    <= '0;
      m_q       <= '0;
      m_valid_q <= 1'b0;
      m_dest_q  <= 1'b0;
    end else begin
      arch_q    <= arch_d;
      m_q       <= m_d;
      m_valid_q <= m_valid_d;
      m_dest_q  <= m_dest_d;
    end
  end

  assign bus.ZA     = fwd[0].z;
  assign bus.NA     = fwd[0].n;
  assign bus.CA     = fwd[0].c;
  assign bus.ZB     = fwd[1].z;
  assign bus.NB     = fwd[1].n;
  assign bus.CB     = fwd[1].c;
  assign bus.pend_a = m_valid_q && !m_dest_q;
  assign bus.pend_b = m_valid_q &&  m_dest_q;
endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed bench for branch_flag_unit: stimulus queues the expected flag vector
// {ZA,NA,CA,ZB,NB,CB,pend_a,pend_b}; a monitor pops and compares after each edge.
module tb_branch_flag_unit;
  logic clk;
  logic reset;

  branch_flag_if #(.DATA_WIDTH(8)) bus ();

  branch_flag_unit #(.DATA_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] exp;
    string      name;
  } sb_t;

  sb_t q[$];
  int  n_cmp = 0;
  int  n_mis = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] actual();
    return {bus.ZA, bus.NA, bus.CA, bus.ZB, bus.NB, bus.CB, bus.pend_a, bus.pend_b};
  endfunction

  // Monitor: one check per edge (or async reset rise) for which an expectation is queued.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (actual() !== e.exp) begin
          n_mis++;
          $display("FAIL %s: got %b expected %b (ZA NA CA ZB NB CB pa pb)", e.name, actual(), e.exp);
        end
      end
    end
  end

  // Drive one cycle's inputs (called at edge+2), queue the state expected after the next edge.
  task automatic cyc(input logic v, input logic d, input logic [7:0] res, input logic c,
                     input logic cwe, input logic st, input logic fl,
                     input logic [7:0] exp, input string name);
    sb_t e;
    bus.ex_valid    = v;
    bus.ex_dest     = d;
    bus.ex_result   = res;
    bus.ex_carry    = c;
    bus.ex_carry_we = cwe;
    bus.stall       = st;
    bus.flush       = fl;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic [7:0] exp, input string name);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, exp, name);
  endtask

  initial begin
    sb_t e;
    reset = 1'b1;
    bus.ex_valid = 1'b0; bus.ex_dest = 1'b0; bus.ex_result = '0;
    bus.ex_carry = 1'b0; bus.ex_carry_we = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    idle(8'b000_000_00, "reset_state");

    // A <- 0x00 with carry set
    cyc(1, 0, 8'h00, 1, 1, 0, 0, 8'b101_000_10, "a_zero_mem");
    cyc(0, 1, 8'hAA, 1, 1, 0, 0, 8'b101_000_00, "a_zero_commit_ignore_ex");

    // Carry chain: arch CA=0 underneath, forwarded CA=1 must be preserved
    cyc(1, 0, 8'h01, 0, 1, 0, 0, 8'b000_000_10, "a_01_c0");
    cyc(1, 0, 8'h00, 1, 1, 0, 0, 8'b101_000_10, "a_00_c1");
    cyc(1, 0, 8'h80, 0, 0, 0, 0, 8'b011_000_10, "a_80_cpreserve");
    idle(8'b011_000_00, "a_80_commit");

    // Interleaved A then B
    cyc(1, 0, 8'h05, 0, 1, 0, 0, 8'b000_000_10, "a_05");
    cyc(1, 1, 8'hFF, 0, 1, 0, 0, 8'b000_010_01, "b_ff");
    idle(8'b000_010_00, "b_ff_commit");

    // Stall with B pending; concurrent EX not captured
    cyc(1, 1, 8'h80, 1, 1, 0, 0, 8'b000_011_01, "b_80_c1");
    cyc(1, 0, 8'h00, 1, 1, 1, 0, 8'b000_011_01, "stall_1");
    cyc(1, 0, 8'h00, 1, 1, 1, 0, 8'b000_011_01, "stall_2");
    cyc(1, 0, 8'h00, 1, 1, 1, 0, 8'b000_011_01, "stall_3");
    idle(8'b000_011_00, "stall_release_commit");

    // Flush, and flush under stall
    cyc(1, 0, 8'h00, 1, 1, 0, 1, 8'b000_011_00, "flush_drop");
    cyc(1, 0, 8'h00, 1, 1, 1, 1, 8'b000_011_00, "stall_flush");
    idle(8'b000_011_00, "after_stall_flush");

    // MEM entry commits despite flush of the EX instruction
    cyc(1, 1, 8'h00, 0, 1, 0, 0, 8'b000_100_01, "b_00_c0");
    cyc(1, 0, 8'h00, 1, 1, 0, 1, 8'b000_100_00, "flush_mem_commits");

    // B carry preservation back-to-back
    cyc(1, 1, 8'hFF, 1, 1, 0, 0, 8'b000_011_01, "b_ff_c1");
    cyc(1, 1, 8'h00, 0, 0, 0, 0, 8'b000_101_01, "b_00_cpreserve");

    // Asynchronous reset between edges with an entry pending
    #1;
    e.exp  = 8'b000_000_00;
    e.name = "async_reset";
    q.push_back(e);
    reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    idle(8'b000_000_00, "post_reset");

    // Every queued expectation must have been consumed
    n_cmp++;
    if (q.size() != 0) begin
      n_mis++;
      $display("FAIL sb_drain: got %0d leftover expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
